// File: rtl/mips_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/return, decode hand-off,
// execute redirect and fault reporting.
interface mips_fetch_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    imem_pc;
    logic                   imem_req;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [PC_WIDTH-1:0]    dec_pc;
    logic [PC_WIDTH-1:0]    dec_pc_plus4;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   fetch_fault;
    logic [PC_WIDTH-1:0]    fault_pc;

    modport master (
        output imem_pc, imem_req, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
               fetch_fault, fault_pc,
        input  imem_instr, dec_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_pc, imem_req, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
               fetch_fault, fault_pc,
        output imem_instr, dec_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: sequential word fetch from a 1-cycle sync
// instruction memory, small fetch buffer toward decode, redirect/flush handling.
module mips_fetch_stage #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  FIFO_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_fetch_if.master  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]      DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [PC_WIDTH-1:0]    pc_r;
    logic                   inflight_r;
    logic [PC_WIDTH-1:0]    inflight_pc_r;
    logic                   fetch_fault_r;
    logic [PC_WIDTH-1:0]    fault_pc_r;

    logic [INSTR_WIDTH-1:0] fifo_instr_r [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    fifo_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic                   dec_valid_s;
    logic                   accept_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   misaligned_s;
    logic [CNT_W:0]         occ_s;
    logic                   issue_s;

    // Occupancy accounting and fetch-issue decision; a redirect suppresses both issue and pop.
    always_comb begin
        dec_valid_s  = (count_r != {CNT_W{1'b0}});
        accept_s     = dec_valid_s & bus.dec_ready;
        pop_s        = accept_s & ~bus.redirect_valid;
        push_s       = inflight_r & ~bus.redirect_valid;
        misaligned_s = (bus.redirect_pc[1:0] != 2'b00);
        occ_s        = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r}
                       - {{CNT_W{1'b0}}, accept_s};
        if (!rst_n) begin
            issue_s = 1'b0;
        end else if ((state_r == ST_RUN) && !bus.redirect_valid && (occ_s < DEPTH_V)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch control FSM: PC, in-flight tracking and sticky misalignment fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_WIDTH{1'b0}};
            fetch_fault_r <= 1'b0;
            fault_pc_r    <= {PC_WIDTH{1'b0}};
        end else if (bus.redirect_valid) begin
            pc_r       <= bus.redirect_pc;
            inflight_r <= 1'b0;
            if (misaligned_s) begin
                state_r       <= ST_FAULT;
                fetch_fault_r <= 1'b1;
                fault_pc_r    <= bus.redirect_pc;
            end else begin
                state_r       <= ST_RUN;
                fetch_fault_r <= 1'b0;
                fault_pc_r    <= {PC_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    inflight_r <= issue_s;
                    if (issue_s) begin
                        pc_r          <= pc_r + PC_STEP;
                        inflight_pc_r <= pc_r;
                    end
                end
                ST_FAULT: begin
                    inflight_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_RUN;
                    inflight_r <= 1'b0;
                end
            endcase
        end
    end

    // Fetch buffer: returned words enter at the tail, decode reads the registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= {INSTR_WIDTH{1'b0}};
                fifo_pc_r[i]    <= {PC_WIDTH{1'b0}};
            end
        end else if (bus.redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_instr_r[wr_ptr_r] <= bus.imem_instr;
                fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
                wr_ptr_r               <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.imem_pc      = pc_r;
    assign bus.imem_req     = issue_s;
    assign bus.dec_valid    = dec_valid_s;
    assign bus.dec_instr    = fifo_instr_r[rd_ptr_r];
    assign bus.dec_pc       = fifo_pc_r[rd_ptr_r];
    assign bus.dec_pc_plus4 = fifo_pc_r[rd_ptr_r] + PC_STEP;
    assign bus.fetch_fault  = fetch_fault_r;
    assign bus.fault_pc     = fault_pc_r;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed vector table, wrap-around instance,
// random traffic against a queue-based reference model, async reset check.
module tb_mips_fetch_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mips_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) fif  ();
    mips_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) fif2 ();

    mips_fetch_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(2),
                       .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(fif.master));

    mips_fetch_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(2),
                       .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(fif2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle synchronous read returning pc>>2, garbage when idle.
    always @(posedge clk) begin
        fif.imem_instr  <= fif.imem_req  ? (fif.imem_pc  >> 2) : 32'hDEAD_BEEF;
        fif2.imem_instr <= fif2.imem_req ? (fif2.imem_pc >> 2) : 32'hDEAD_BEEF;
    end

    // Reference model state: buffered PCs in a queue, one optional word in flight.
    logic [31:0] m_q [$];
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] m_fpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = 32'h0;
        m_pc          = 32'h0;
        m_fault       = 1'b0;
        m_fpc         = 32'h0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_req",  {31'd0, fif.imem_req},    32'h0);
        chk("rst_dec_valid", {31'd0, fif.dec_valid},   32'h0);
        chk("rst_dec_instr", fif.dec_instr,            32'h0);
        chk("rst_dec_pc",    fif.dec_pc,               32'h0);
        chk("rst_fault",     {31'd0, fif.fetch_fault}, 32'h0);
        chk("rst_fault_pc",  fif.fault_pc,             32'h0);
        chk("rst_imem_pc",   fif.imem_pc,              32'h0);
    endtask

    // Entered just after a rising edge; applies inputs, checks at the falling edge, advances the model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bit          exp_valid;
        bit          pop;
        bit          exp_req;
        int          occ;
        logic [31:0] hp;
        fif.dec_ready      = rdy;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        @(negedge clk);
        exp_valid = (m_q.size() != 0);
        pop       = exp_valid && rdy;
        occ       = m_q.size() + (m_inflight ? 1 : 0) - (pop ? 1 : 0);
        exp_req   = !m_fault && !rv && (occ < 2);
        chk("m_dec_valid", {31'd0, fif.dec_valid},   {31'd0, exp_valid});
        chk("m_imem_req",  {31'd0, fif.imem_req},    {31'd0, exp_req});
        chk("m_imem_pc",   fif.imem_pc,              m_pc);
        chk("m_fault",     {31'd0, fif.fetch_fault}, {31'd0, m_fault});
        chk("m_fault_pc",  fif.fault_pc,             m_fpc);
        if (exp_valid) begin
            hp = m_q[0];
            chk("m_dec_pc",     fif.dec_pc,       hp);
            chk("m_dec_instr",  fif.dec_instr,    hp >> 2);
            chk("m_dec_plus4",  fif.dec_pc_plus4, hp + 32'd4);
        end
        if (rv) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc       = rpc;
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_fpc   = rpc;
            end else begin
                m_fault = 1'b0;
                m_fpc   = 32'h0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_pc);
            m_inflight = exp_req;
            if (exp_req) begin
                m_inflight_pc = m_pc;
                m_pc          = m_pc + 32'd4;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_ipc;
        logic        e_fault;
        logic [31:0] e_fpc;
    } vec_t;

    function automatic vec_t mkv(logic rdy, logic rv, logic [31:0] rpc, logic e_valid,
                                 logic [31:0] e_pc, logic e_req, logic [31:0] e_ipc,
                                 logic e_fault, logic [31:0] e_fpc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_req = e_req; v.e_ipc = e_ipc; v.e_fault = e_fault; v.e_fpc = e_fpc;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        total = 0;
        bad   = 0;
        // Cycle 0 is the first cycle after reset release.
        tbl[0]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0);
        tbl[1]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h0);
        tbl[2]  = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b1, 32'h08, 1'b0, 32'h0);
        tbl[3]  = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'h0C, 1'b0, 32'h0);
        tbl[4]  = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h10, 1'b0, 32'h0);
        tbl[5]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 32'h14, 1'b0, 32'h0);
        tbl[6]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 32'h14, 1'b0, 32'h0);
        tbl[7]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 32'h14, 1'b0, 32'h0);
        tbl[8]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 32'h14, 1'b0, 32'h0);
        tbl[9]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 32'h14, 1'b0, 32'h0);
        tbl[10] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h14, 1'b0, 32'h0);
        tbl[11] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h18, 1'b0, 32'h0);
        tbl[12] = mkv(1'b1, 1'b1, 32'h40, 1'b1, 32'h14, 1'b0, 32'h1C, 1'b0, 32'h0);
        tbl[13] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0);
        tbl[14] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h0);
        tbl[15] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 32'h48, 1'b0, 32'h0);
        tbl[16] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h4C, 1'b0, 32'h0);
        tbl[17] = mkv(1'b1, 1'b1, 32'h42, 1'b1, 32'h48, 1'b0, 32'h50, 1'b0, 32'h0);
        tbl[18] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h42, 1'b1, 32'h42);
        tbl[19] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h42, 1'b1, 32'h42);
        tbl[20] = mkv(1'b1, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 32'h42, 1'b1, 32'h42);
        tbl[21] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80, 1'b0, 32'h0);
        tbl[22] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h84, 1'b0, 32'h0);
        tbl[23] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h80, 1'b1, 32'h88, 1'b0, 32'h0);

        rst_n               = 1'b1;
        fif.dec_ready       = 1'b0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_pc     = 32'h0;
        fif2.dec_ready      = 1'b1;
        fif2.redirect_valid = 1'b0;
        fif2.redirect_pc    = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("t%0d_valid", i), {31'd0, fif.dec_valid},   {31'd0, tbl[i].e_valid});
            chk($sformatf("t%0d_req", i),   {31'd0, fif.imem_req},    {31'd0, tbl[i].e_req});
            chk($sformatf("t%0d_ipc", i),   fif.imem_pc,              tbl[i].e_ipc);
            chk($sformatf("t%0d_fault", i), {31'd0, fif.fetch_fault}, {31'd0, tbl[i].e_fault});
            chk($sformatf("t%0d_fpc", i),   fif.fault_pc,             tbl[i].e_fpc);
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i),    fif.dec_pc,       tbl[i].e_pc);
                chk($sformatf("t%0d_instr", i), fif.dec_instr,    tbl[i].e_pc >> 2);
                chk($sformatf("t%0d_plus4", i), fif.dec_pc_plus4, tbl[i].e_pc + 32'd4);
            end
            if (i >= 2 && i <= 5) begin
                chk($sformatf("wrap%0d_valid", i), {31'd0, fif2.dec_valid}, 32'h1);
                chk($sformatf("wrap%0d_pc", i), fif2.dec_pc,
                    32'hFFFF_FFF8 + 32'(4 * (i - 2)));
            end
            next_cycle();
        end

        // Random traffic: mixed decode back-pressure and occasional (sometimes misaligned) redirects.
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step(rdy, rv, rpc);
            next_cycle();
        end

        // Set a fault, then reset mid-cycle: outputs must clear without a clock edge.
        step(1'b1, 1'b1, 32'h0000_0123);
        next_cycle();
        step(1'b1, 1'b0, 32'h0);
        next_cycle();
        step(1'b0, 1'b1, 32'h0000_0200);
        next_cycle();
        step(1'b0, 1'b0, 32'h0);
        next_cycle();
        step(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
